// File: rtl/ram_burst_reader.sv
// Burst read engine: walks a RAM address range and streams words out with a 2-entry skid FIFO.
// Optional start-range rejection is compiled in with RAM_BURST_READER_ERR_EN.
module ram_burst_reader #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 4
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic [AWIDTH-1:0] start_addr_i,
    input  logic [AWIDTH:0]   len_i,
    output logic              busy_o,
    output logic [AWIDTH-1:0] rdpntr_o,
    input  logic [DWIDTH-1:0] q_i,
    output logic [DWIDTH-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              last_o,
    output logic              done_o,
    output logic              err_o
);

    localparam logic [AWIDTH:0] LMAX = (AWIDTH+1)'(2**AWIDTH);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DONE
    } state_t;

    state_t            state;
    logic [AWIDTH-1:0] addr_q;
    logic [AWIDTH:0]   issue_cnt;
    logic [AWIDTH:0]   xfer_cnt;
    logic              inflight;
    logic [DWIDTH-1:0] fifo [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;
    logic              err_q;

    logic [AWIDTH:0]   len_clamp;
    logic              range_err;
    logic              xfer;
    logic [2:0]        committed;
    logic              issue;

    assign len_clamp = (len_i > LMAX) ? LMAX : len_i;

`ifdef RAM_BURST_READER_ERR_EN
    assign range_err = ({1'b0, start_addr_i} + len_clamp) > LMAX;
`else
    assign range_err = 1'b0;
`endif

    assign valid_o = (count != 2'd0);
    assign xfer    = valid_o & ready_i;

    // Slots already promised: stored words plus the read still in flight.
    assign committed = {1'b0, count} + {2'b0, inflight} - {2'b0, xfer};
    assign issue     = (state == READ) && (issue_cnt != '0) && (committed < 3'd2);

    assign data_o   = fifo[rd_ptr];
    assign last_o   = valid_o && (xfer_cnt == (AWIDTH+1)'(1));
    assign busy_o   = (state == READ);
    assign done_o   = (state == DONE);
    assign rdpntr_o = addr_q;
    assign err_o    = err_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state     <= IDLE;
            addr_q    <= '0;
            issue_cnt <= '0;
            xfer_cnt  <= '0;
            inflight  <= 1'b0;
            fifo[0]   <= '0;
            fifo[1]   <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            count     <= 2'd0;
            err_q     <= 1'b0;
        end else begin
            err_q    <= 1'b0;
            inflight <= issue;

            if (inflight) begin
                fifo[wr_ptr] <= q_i;
                wr_ptr       <= ~wr_ptr;
            end
            if (xfer) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, inflight} - {1'b0, xfer};

            if (issue) begin
                addr_q    <= addr_q + 1'b1;
                issue_cnt <= issue_cnt - 1'b1;
            end

            unique case (state)
                IDLE: begin
                    if (start_i) begin
                        if (range_err) begin
                            err_q <= 1'b1;
                        end else if (len_clamp == '0) begin
                            state <= DONE;
                        end else begin
                            state     <= READ;
                            addr_q    <= start_addr_i;
                            issue_cnt <= len_clamp;
                            xfer_cnt  <= len_clamp;
                        end
                    end
                end
                READ: begin
                    if (xfer) begin
                        xfer_cnt <= xfer_cnt - 1'b1;
                        if (xfer_cnt == (AWIDTH+1)'(1)) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/ram_burst_reader.md
# ram_burst_reader

Read-side burst engine for the team's simple dual-port RAM (1-cycle registered read latency). On a start command it walks a contiguous address range and streams each word out over a valid/ready interface, absorbing downstream back-pressure in a 2-entry output buffer. The buffer keeps a RAM read from ever being lost. It sits between the RAM's read port and any consumer that needs block reads (packet egress, debug dump).

## Interface
- DWIDTH, 8, data word width; must match the RAM.
- AWIDTH, 4, address width; RAM depth is 2**AWIDTH.

- clk_i  input  1  single clock for all logic; RAM shares it.
- rst_n_i  input  1  asynchronous active-low reset.
- start_i  input  1  start command; sampled only in IDLE.
- start_addr_i  input  AWIDTH  first address of the burst.
- len_i  input  AWIDTH+1  burst length in words, 0..2**AWIDTH.
- busy_o  output  1  high from start acceptance until done.
- rdpntr_o  output  AWIDTH  RAM read address.
- q_i  input  DWIDTH  RAM read data, valid one cycle after rdpntr_o is sampled.
- data_o  output  DWIDTH  output word.
- valid_o  output  1  data_o valid.
- ready_i  input  1  consumer accepts; transfer on valid_o && ready_i.
- last_o  output  1  qualifies the final word of the burst.
- done_o  output  1  one-cycle pulse at burst end.
- err_o  output  1  one-cycle reject pulse; constant 0 unless RAM_BURST_READER_ERR_EN is defined.

## Operation
- States:
  - IDLE -> READ on start_i with clamped len != 0.
  - IDLE -> DONE on start_i with len == 0.
  - READ -> DONE once all words are issued and the final word has transferred.
  - DONE -> IDLE unconditionally.
- len_i above 2**AWIDTH is clamped to 2**AWIDTH.
- Start acceptance latches start_addr_i into the address counter and the clamped length into the issue and transfer counters.
- A read is issued in a cycle when all of the following hold:
  - state is READ;
  - the issue counter is nonzero;
  - (buffer occupancy + in-flight read − transfer this cycle) < 2.
- On each issue, the address counter increments and the issue counter decrements.
- An in-flight read captures q_i into the buffer on the following edge.
- Address arithmetic is modulo 2**AWIDTH: address 2**AWIDTH−1 wraps to 0.
- Buffer is a 2-entry FIFO. data_o and valid_o come from its head; last_o is high when the head is the final word.
- start_i is ignored outside IDLE.
- rst_n_i low at any time, including mid-burst, returns the block to IDLE with the buffer emptied. No partial output survives.

## Timing
- Reset values:
  - busy_o = 0, valid_o = 0, last_o = 0, done_o = 0, err_o = 0;
  - rdpntr_o = 0, data_o = 0.
- start_i high in cycle n: busy_o is high from n+1 and rdpntr_o = start_addr_i in n+1.
- First read is issued in n+1; first valid_o is in n+3.
- With ready_i held high, sustained throughput is one word per cycle. A burst of L words has its final transfer in cycle n+L+2.
- done_o pulses in the cycle after the final transfer (the DONE state). busy_o drops in that same cycle.
- len = 0: done_o pulses in n+1 and busy_o stays 0.
- Back-pressure:
  - data_o, valid_o and last_o hold stable while valid_o && !ready_i;
  - issue stops when the buffer is committed full;
  - no word is dropped or duplicated.
- A new start_i is accepted in the DONE cycle + 1 (IDLE) at the earliest.

## Configuration
- RAM_BURST_READER_ERR_EN defined:
  - a start where start_addr_i + clamped len > 2**AWIDTH is rejected;
  - err_o pulses in n+1, no reads are issued, busy_o and done_o stay 0, and the block stays in IDLE.
- Not defined: the range check is absent, err_o is tied 0, and bursts wrap modulo 2**AWIDTH.

## Test plan
- RAM preloaded mem[k] = k+0x10, start_addr 3, len 4, ready_i = 1:
  - data_o = 0x13, 0x14, 0x15, 0x16 in cycles n+3..n+6;
  - last_o is high with 0x16;
  - done_o pulses in n+7.
- Same burst with ready_i toggling 1,0,0,1,…: identical 4-word sequence, data held stable while stalled, no loss.
- start_addr 14, len 4, macro off: words from addresses 14, 15, 0, 1. Same start with macro on: err_o pulses, no valid_o, busy_o stays 0.
- len_i = 0: done_o pulses in n+1, valid_o never rises. len_i = 31 (AWIDTH=4): exactly 16 words are transferred.
- rst_n_i asserted after 2 of 8 words:
  - all outputs return to reset values immediately;
  - a new burst (addr 0, len 2) afterwards yields mem[0], mem[1] only.
- start_i pulsed again mid-burst: ignored, and the original burst completes unchanged.
